// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle for pipe_skid_stage: upstream valid/ready + entry fields,
// downstream valid/ready + entry fields, and the exception flush request.
interface pipe_skid_stage_if #(
    parameter int DATA_W = 96,
    parameter int PC_W   = 32,
    parameter int EXC_W  = 5
);
    logic              req;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [31:0]       in_instr;
    logic [DATA_W-1:0] in_data;
    logic              in_bd;
    logic [EXC_W-1:0]  in_exc;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [31:0]       out_instr;
    logic [DATA_W-1:0] out_data;
    logic              out_bd;
    logic [EXC_W-1:0]  out_exc;

    modport slave (
        input  req, in_valid, in_pc, in_instr, in_data, in_bd, in_exc, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_data, out_bd, out_exc
    );

    modport master (
        output req, in_valid, in_pc, in_instr, in_data, in_bd, in_exc, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_data, out_bd, out_exc
    );
endinterface

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional downstream-stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_skid_stage #(
    parameter int              DATA_W   = 96,
    parameter int              PC_W     = 32,
    parameter int              EXC_W    = 5,
    parameter logic [PC_W-1:0] FLUSH_PC = 32'h0000_4180,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    pipe_skid_stage_if.slave bus,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [31:0]       instr;
        logic [DATA_W-1:0] data;
        logic              bd;
        logic [EXC_W-1:0]  exc;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q;
    entry_t main_q;
    entry_t skid_q;
    logic   in_ready_q;
    logic   out_valid_q;
    entry_t in_entry;
    entry_t flush_entry;
    logic   in_fire;
    logic   out_fire;

    assign in_entry    = {bus.in_pc, bus.in_instr, bus.in_data, bus.in_bd, bus.in_exc};
    assign flush_entry = {FLUSH_PC, 32'h0000_0000, {DATA_W{1'b0}}, 1'b0, {EXC_W{1'b0}}};
    assign in_fire     = bus.in_valid & in_ready_q;
    assign out_fire    = out_valid_q & bus.out_ready;

    // Slot state machine; in_ready is recomputed alongside state so it never
    // depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (bus.req) begin
            state_q     <= ST_EMPTY;
            main_q      <= flush_entry;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_q      <= in_entry;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ONE;
                    end else begin
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q      <= in_entry;
                        state_q     <= ST_ONE;
                    end else if (in_fire) begin
                        skid_q      <= in_entry;
                        in_ready_q  <= 1'b0;
                        state_q     <= ST_FULL;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end else begin
                        state_q     <= ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_q      <= skid_q;
                        skid_q      <= '0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_ONE;
                    end else begin
                        state_q     <= ST_FULL;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = main_q.pc;
    assign bus.out_instr = main_q.instr;
    assign bus.out_data  = main_q.data;
    assign bus.out_bd    = main_q.bd;
    assign bus.out_exc   = main_q.exc;

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // Saturating count of cycles the downstream refuses a valid entry.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !bus.out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Only reset clears the counter; a flush keeps the history.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_pipe_skid_stage;
    localparam int DATA_W = 96;
    localparam int PC_W   = 32;
    localparam int EXC_W  = 5;
    localparam int CNT_W  = 16;
    localparam logic [PC_W-1:0] FLUSH_PC = 32'h0000_4180;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [31:0]       instr;
        logic [DATA_W-1:0] data;
        logic              bd;
        logic [EXC_W-1:0]  exc;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    logic [CNT_W-1:0] stall_cnt;
    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    pipe_skid_stage_if #(.DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W)) bus ();

    pipe_skid_stage #(
        .DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W), .FLUSH_PC(FLUSH_PC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference: FIFO of at most two entries plus the last value shown.
    ent_t q[$];
    ent_t disp = '0;
    int   m_stall = 0;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            disp = '0;
            m_stall = 0;
        end else begin
            if (q.size() > 0 && !bus.out_ready && m_stall < CNT_MAX) m_stall++;
            if (bus.req) begin
                q.delete();
                disp = '0;
                disp.pc = FLUSH_PC;
            end else begin
                bit inf, outf;
                outf = (q.size() > 0) && bus.out_ready;
                inf  = bus.in_valid && (q.size() < 2);
                if (outf) void'(q.pop_front());
                if (inf) q.push_back(ent_t'({bus.in_pc, bus.in_instr, bus.in_data, bus.in_bd, bus.in_exc}));
                if (q.size() > 0) disp = q[0];
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int exp_stall;
`ifdef PIPE_STALL_CNT_EN
            exp_stall = m_stall;
`else
            exp_stall = 0;
`endif
            check("out_valid", 128'(bus.out_valid), 128'(q.size() > 0));
            check("in_ready",  128'(bus.in_ready),  128'(q.size() < 2));
            check("out_pc",    128'(bus.out_pc),    128'(disp.pc));
            check("out_instr", 128'(bus.out_instr), 128'(disp.instr));
            check("out_data",  128'(bus.out_data),  128'(disp.data));
            check("out_bd",    128'(bus.out_bd),    128'(disp.bd));
            check("out_exc",   128'(bus.out_exc),   128'(disp.exc));
            check("stall_cnt", 128'(stall_cnt),     128'(exp_stall));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit ordy);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = pc ^ 32'hDEAD_0000;
        bus.in_data   = {$urandom, $urandom, $urandom};
        bus.in_bd     = 1'b0;
        bus.in_exc    = 5'd0;
        bus.out_ready = ordy;
    endtask

    initial begin
        logic [95:0] a5;
        a5 = {12{8'hA5}};
        reset = 1'b1;
        bus.req = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;

        // Reset then idle
        step();
        step();
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_in_ready",  128'(bus.in_ready),  128'd1);
        check("rst_out_pc",    128'(bus.out_pc),    128'd0);
        check("rst_stall",     128'(stall_cnt),     128'd0);

        // Streaming
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h3000 + 32'(4 * i), 1'b1);
            step();
            check("stream_pc", 128'(bus.out_pc), 128'(32'h3000 + 32'(4 * i)));
            check("stream_in_ready", 128'(bus.in_ready), 128'd1);
        end
        drive(1'b0, 32'h0, 1'b1);
        step();
        check("stream_drain_valid", 128'(bus.out_valid), 128'd0);
        check("stream_sticky_pc",   128'(bus.out_pc),    128'(32'h300C));

        // Skid fill
        drive(1'b1, 32'h3000, 1'b0); step();
        drive(1'b1, 32'h3004, 1'b0); step();
        check("fill_in_ready", 128'(bus.in_ready), 128'd0);
        drive(1'b1, 32'h3008, 1'b0); step();
        check("fill_hold_pc", 128'(bus.out_pc), 128'(32'h3000));
        drive(1'b1, 32'h3008, 1'b1); step();
        check("fill_drain1_pc", 128'(bus.out_pc),   128'(32'h3004));
        check("fill_ready_back", 128'(bus.in_ready), 128'd1);
        step();
        check("fill_drain2_pc", 128'(bus.out_pc), 128'(32'h3008));
        drive(1'b0, 32'h0, 1'b1); step();

        // Flush in FULL
        drive(1'b1, 32'h3000, 1'b0); step();
        drive(1'b1, 32'h3004, 1'b0); step();
        drive(1'b1, 32'h300C, 1'b0);
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        check("flush_valid",    128'(bus.out_valid), 128'd0);
        check("flush_pc",       128'(bus.out_pc),    128'(32'h0000_4180));
        check("flush_instr",    128'(bus.out_instr), 128'd0);
        check("flush_exc",      128'(bus.out_exc),   128'd0);
        check("flush_in_ready", 128'(bus.in_ready),  128'd1);
        drive(1'b0, 32'h0, 1'b1);
        repeat (3) step();

        // reset and req together
        drive(1'b1, 32'h3010, 1'b0); step();
        reset = 1'b1;
        bus.req = 1'b1;
        step();
        reset = 1'b0;
        bus.req = 1'b0;
        check("rst_req_pc", 128'(bus.out_pc), 128'd0);

        // Payload pass-through
        drive(1'b1, 32'h3020, 1'b1);
        bus.in_exc  = 5'd12;
        bus.in_bd   = 1'b1;
        bus.in_data = a5;
        step();
        check("pay_data", 128'(bus.out_data), 128'(a5));
        check("pay_bd",   128'(bus.out_bd),   128'd1);
        check("pay_exc",  128'(bus.out_exc),  128'd12);
        drive(1'b0, 32'h0, 1'b1); step();

`ifdef PIPE_STALL_CNT_EN
        // Stall count, kept across a flush
        reset = 1'b1; step(); reset = 1'b0;
        drive(1'b1, 32'h3030, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0);
        repeat (7) step();
        check("stall_7", 128'(stall_cnt), 128'd7);
        bus.req = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.req = 1'b0;
        check("stall_after_req", 128'(stall_cnt), 128'd7);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_pc     = $urandom;
            bus.in_instr  = $urandom;
            bus.in_data   = {$urandom, $urandom, $urandom};
            bus.in_bd     = 1'($urandom);
            bus.in_exc    = 5'($urandom_range(0, 31));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.req       = ($urandom_range(0, 49) == 0);
            reset         = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        bus.req = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
